// File: rtl/linus_pkg.sv
// Shared pipeline definitions: opcode encodings, instruction field positions
// and the issue-scoreboard sequencer states.
package linus_pkg;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_INC = 3'b011;

   localparam int OPC_MSB = 6;
   localparam int OPC_LSB = 4;
   localparam int RD_LSB  = 2;
   localparam int RS1_LSB = 2;
   localparam int RS2_LSB = 0;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } sb_state_t;

   function automatic logic op_writes(input logic [2:0] op);
      return op != OP_NOP;
   endfunction

   function automatic logic op_uses_rs2(input logic [2:0] op);
      return (op != OP_NOP) && (op != OP_INC);
   endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// ID-stage issue bundle: decoded IF/ID fields, WB retire, halt request and
// the scoreboard's stall/status outputs.
interface issue_scoreboard_if #(
   parameter int ENC_W   = 2,
   parameter int STALL_W = 16
);
   logic               id_valid;
   logic [2:0]         id_opcode;
   logic [ENC_W-1:0]   id_rd;
   logic [ENC_W-1:0]   id_rs1;
   logic [ENC_W-1:0]   id_rs2;
   logic               wb_valid;
   logic [ENC_W-1:0]   wb_rd;
   logic               halt_req;
   logic               stall;
   logic               issue;
   logic               busy;
   logic               halted;
   logic               err_underflow;
   logic [STALL_W-1:0] stall_cycles;

   modport master (
      output id_valid, id_opcode, id_rd, id_rs1, id_rs2, wb_valid, wb_rd, halt_req,
      input  stall, issue, busy, halted, err_underflow, stall_cycles
   );

   modport slave (
      input  id_valid, id_opcode, id_rd, id_rs1, id_rs2, wb_valid, wb_rd, halt_req,
      output stall, issue, busy, halted, err_underflow, stall_cycles
   );
endinterface

// File: rtl/sb_pend_counter.sv
// Pending-write counter for one architectural register. A simultaneous issue
// and retire cancel out; a retire with nothing pending pulses o_underflow.
module sb_pend_counter #(
   parameter int CNT_W = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_zero,
   output logic o_max,
   output logic o_next_zero,
   output logic o_underflow
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_next;

   always_comb begin
      w_next      = r_count;
      o_underflow = 1'b0;
      if (i_inc && !i_dec) begin
         w_next = r_count + ONE;
      end else if (i_dec && !i_inc) begin
         if (r_count == '0) o_underflow = 1'b1;
         else               w_next      = r_count - ONE;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_count <= '0;
      else         r_count <= w_next;
   end

   assign o_zero      = (r_count == '0);
   assign o_max       = (r_count == '1);
   assign o_next_zero = (w_next == '0);

endmodule

// File: rtl/issue_scoreboard.sv
// ID-stage issue controller: per-register pending-write counters gate issue,
// WB retires drain them, and a halt sequencer freezes issue once drained.
module issue_scoreboard
   import linus_pkg::*;
#(
   parameter int NUM_REGS = 4,
   parameter int ENC_W    = 2,
   parameter int CNT_W    = 2,
   parameter int STALL_W  = 16
) (
   input logic                clk,
   input logic                resetn,
   issue_scoreboard_if.slave  bus
);

   localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

   sb_state_t           r_state;
   sb_state_t           w_state_next;
   logic                r_err_underflow;
   logic [STALL_W-1:0]  r_stall_cycles;

   logic [ENC_W-1:0]    w_rd;
   logic [ENC_W-1:0]    w_rs1;
   logic [ENC_W-1:0]    w_rs2;
   logic [ENC_W-1:0]    w_wb_rd;
   logic [NUM_REGS-1:0] w_inc;
   logic [NUM_REGS-1:0] w_dec;
   logic [NUM_REGS-1:0] w_zero;
   logic [NUM_REGS-1:0] w_max;
   logic [NUM_REGS-1:0] w_next_zero;
   logic [NUM_REGS-1:0] w_underflow;
   logic                w_writes;
   logic                w_uses_rs2;
   logic                w_hazard;
   logic                w_stall;
   logic                w_issue;

   assign w_rd       = bus.id_rd;
   assign w_rs1      = bus.id_rs1;
   assign w_rs2      = bus.id_rs2;
   assign w_wb_rd    = bus.wb_rd;
   assign w_writes   = op_writes(bus.id_opcode);
   assign w_uses_rs2 = op_uses_rs2(bus.id_opcode);

   // Registered counts only: a retire in this same cycle does not unblock.
   assign w_hazard = !w_zero[w_rs1]
                   || (w_uses_rs2 && !w_zero[w_rs2])
                   || w_max[w_rd];

   assign w_stall = bus.id_valid && ((r_state != RUN) || (w_writes && w_hazard));
   assign w_issue = bus.id_valid && !w_stall;

   always_comb begin
      w_inc          = '0;
      w_dec          = '0;
      w_inc[w_rd]    = w_issue && w_writes;
      w_dec[w_wb_rd] = bus.wb_valid;
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
      sb_pend_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk         (clk),
         .resetn      (resetn),
         .i_inc       (w_inc[g]),
         .i_dec       (w_dec[g]),
         .o_zero      (w_zero[g]),
         .o_max       (w_max[g]),
         .o_next_zero (w_next_zero[g]),
         .o_underflow (w_underflow[g])
      );
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         RUN:     if (bus.halt_req) w_state_next = DRAIN;
         DRAIN:   if (!bus.halt_req)     w_state_next = RUN;
                  else if (&w_next_zero) w_state_next = HALTED;
         HALTED:  if (!bus.halt_req) w_state_next = RUN;
         default: w_state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state         <= RUN;
         r_err_underflow <= 1'b0;
         r_stall_cycles  <= '0;
      end else begin
         r_state         <= w_state_next;
         r_err_underflow <= r_err_underflow | (|w_underflow);
         if (w_stall && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + STALL_ONE;
      end
   end

   assign bus.stall         = w_stall;
   assign bus.issue         = w_issue;
   assign bus.busy          = !(&w_zero);
   assign bus.halted        = (r_state == HALTED);
   assign bus.err_underflow = r_err_underflow;
   assign bus.stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard with a queue-free behavioural model of
// pending writes, halt sequencing and stall accounting.
module tb_issue_scoreboard;
   import linus_pkg::*;

   logic clk;
   logic resetn;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   chk_en   = 0;

   issue_scoreboard_if #(.ENC_W(2), .STALL_W(16)) bus ();

   issue_scoreboard #(
      .NUM_REGS (4),
      .ENC_W    (2),
      .CNT_W    (2),
      .STALL_W  (16)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: pending count per register, 0=RUN 1=DRAIN 2=HALTED.
   int m_pend [4];
   int m_st   = 0;
   bit m_err  = 0;
   int m_scnt = 0;

   function automatic bit m_stall();
      bit wr;
      bit haz;
      wr  = (bus.id_opcode != OP_NOP);
      haz = (m_pend[bus.id_rs1] != 0)
         || (wr && bus.id_opcode != OP_INC && m_pend[bus.id_rs2] != 0)
         || (m_pend[bus.id_rd] == 3);
      return bus.id_valid && (m_st != 0 || (wr && haz));
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      foreach (m_pend[i]) m_pend[i] = 0;
      forever begin
         @(posedge clk or negedge resetn);
         if (!resetn) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_st   = 0;
            m_err  = 0;
            m_scnt = 0;
         end else begin
            bit s;
            bit all0;
            s = m_stall();
            if (bus.id_valid && !s && bus.id_opcode != OP_NOP) m_pend[bus.id_rd]++;
            if (bus.wb_valid) begin
               if (m_pend[bus.wb_rd] > 0) m_pend[bus.wb_rd]--;
               else                       m_err = 1;
            end
            all0 = 1;
            foreach (m_pend[i]) if (m_pend[i] != 0) all0 = 0;
            case (m_st)
               0: if (bus.halt_req) m_st = 1;
               1: if (!bus.halt_req) m_st = 0; else if (all0) m_st = 2;
               default: if (!bus.halt_req) m_st = 0;
            endcase
            if (s && m_scnt < 65535) m_scnt++;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            bit s;
            bit b;
            s = m_stall();
            b = 0;
            foreach (m_pend[i]) if (m_pend[i] != 0) b = 1;
            check("model_stall",  32'(bus.stall),         32'(s));
            check("model_issue",  32'(bus.issue),         32'(bus.id_valid && !s));
            check("model_busy",   32'(bus.busy),          32'(b));
            check("model_halted", 32'(bus.halted),        32'(m_st == 2));
            check("model_err",    32'(bus.err_underflow), 32'(m_err));
            check("model_scnt",   32'(bus.stall_cycles),  32'(m_scnt));
         end
      end
   end

   task automatic drv(input bit v, input logic [2:0] op, input logic [1:0] rd,
                      input logic [1:0] rs1, input logic [1:0] rs2,
                      input bit wv, input logic [1:0] wrd, input bit h);
      bus.id_valid  = v;
      bus.id_opcode = op;
      bus.id_rd     = rd;
      bus.id_rs1    = rs1;
      bus.id_rs2    = rs2;
      bus.wb_valid  = wv;
      bus.wb_rd     = wrd;
      bus.halt_req  = h;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected end before 100000");
      $fatal(1, "timeout");
   end

   initial begin
      resetn = 1'b0;
      drv(0, OP_NOP, 0, 0, 0, 0, 0, 0);
      #2;
      check("rst_busy",   32'(bus.busy),          0);
      check("rst_halted", 32'(bus.halted),        0);
      check("rst_err",    32'(bus.err_underflow), 0);
      check("rst_scnt",   32'(bus.stall_cycles),  0);
      @(posedge clk); #1;
      resetn = 1'b1;
      chk_en = 1;

      // 1: RAW on R1 stalls until the retire is registered
      drv(1, OP_ADD, 1, 1, 0, 0, 0, 0); #1;
      check("t1_add_issue", 32'(bus.issue), 1);
      tick();
      drv(1, OP_INC, 1, 1, 0, 0, 0, 0); #1;
      check("t1_inc_stall", 32'(bus.stall), 1);
      check("t1_busy", 32'(bus.busy), 1);
      tick(); tick();
      drv(1, OP_INC, 1, 1, 0, 1, 1, 0); #1;
      check("t1_stall_same_retire", 32'(bus.stall), 1);
      tick();
      drv(1, OP_INC, 1, 1, 0, 0, 0, 0); #1;
      check("t1_inc_issue", 32'(bus.issue), 1);
      check("t1_scnt", 32'(bus.stall_cycles), 3);
      tick();
      drv(0, OP_NOP, 0, 0, 0, 1, 1, 0); tick(); #1;
      check("t1_idle", 32'(bus.busy), 0);

      // 2: INC ignores rs2, ADD does not
      drv(1, OP_ADD, 1, 0, 0, 0, 0, 0); tick();
      drv(1, OP_ADD, 0, 0, 1, 0, 0, 0); #1;
      check("t2_add_rs2_stall", 32'(bus.stall), 1);
      tick();
      drv(1, OP_INC, 0, 0, 1, 0, 0, 0); #1;
      check("t2_inc_issue", 32'(bus.issue), 1);
      tick();
      drv(0, OP_NOP, 0, 0, 0, 1, 0, 0); tick();
      drv(0, OP_NOP, 0, 0, 0, 1, 1, 0); tick(); #1;
      check("t2_idle", 32'(bus.busy), 0);
      check("t2_scnt", 32'(bus.stall_cycles), 4);

      // 3: concurrent issue and retire
      drv(1, OP_ADD, 0, 1, 1, 0, 0, 0); tick();
      drv(1, OP_ADD, 2, 3, 3, 1, 0, 0); #1;
      check("t3_issue_r2", 32'(bus.issue), 1);
      tick();
      drv(1, OP_ADD, 3, 0, 2, 1, 2, 0); #1;
      check("t3_rs2_pend_stall", 32'(bus.stall), 1);
      tick();
      drv(1, OP_ADD, 3, 0, 2, 0, 0, 0); #1;
      check("t3_r0_r2_clear", 32'(bus.issue), 1);
      tick();
      drv(0, OP_NOP, 0, 0, 0, 1, 3, 0); tick();
      drv(1, OP_ADD, 0, 1, 1, 0, 0, 0); tick();
      drv(1, OP_ADD, 0, 1, 1, 1, 0, 0); #1;
      check("t3_same_reg_issue", 32'(bus.issue), 1);
      tick();
      drv(1, OP_ADD, 1, 0, 0, 0, 0, 0); #1;
      check("t3_r0_still_pend", 32'(bus.stall), 1);
      tick();
      drv(0, OP_NOP, 0, 0, 0, 1, 0, 0); tick(); #1;
      check("t3_idle", 32'(bus.busy), 0);
      check("t3_no_err", 32'(bus.err_underflow), 0);

      // 4: underflow is sticky; pending count saturation blocks issue
      drv(0, OP_NOP, 0, 0, 0, 1, 3, 0); tick(); #1;
      check("t4_err_set", 32'(bus.err_underflow), 1);
      check("t4_busy0", 32'(bus.busy), 0);
      drv(1, OP_ADD, 1, 0, 0, 0, 0, 0); tick();
      drv(0, OP_NOP, 0, 0, 0, 1, 1, 0); tick(); #1;
      check("t4_err_sticky", 32'(bus.err_underflow), 1);
      drv(1, OP_ADD, 3, 0, 0, 0, 0, 0); tick(); tick(); tick();
      #1;
      check("t4_max_stall", 32'(bus.stall), 1);
      tick();
      drv(0, OP_NOP, 0, 0, 0, 1, 3, 0); tick(); tick(); tick();
      drv(0, OP_NOP, 0, 0, 0, 0, 0, 0); #1;
      check("t4_drained", 32'(bus.busy), 0);
      check("t4_scnt", 32'(bus.stall_cycles), 7);

      // 5: halt drains two in-flight writes, then resumes
      drv(1, OP_ADD, 1, 0, 0, 0, 0, 0); tick();
      drv(1, OP_ADD, 2, 0, 0, 0, 0, 0); tick();
      drv(0, OP_NOP, 0, 0, 0, 0, 0, 1); tick();
      drv(1, OP_NOP, 0, 0, 0, 1, 1, 1); #1;
      check("t5_drain_nop_stall", 32'(bus.stall), 1);
      tick();
      drv(1, OP_NOP, 0, 0, 0, 1, 2, 1); #1;
      check("t5_not_yet_halted", 32'(bus.halted), 0);
      tick();
      drv(1, OP_NOP, 0, 0, 0, 0, 0, 1); #1;
      check("t5_halted", 32'(bus.halted), 1);
      check("t5_halted_stall", 32'(bus.stall), 1);
      tick();
      drv(1, OP_NOP, 0, 0, 0, 0, 0, 0); tick();
      drv(1, OP_ADD, 1, 0, 0, 0, 0, 0); #1;
      check("t5_resume_issue", 32'(bus.issue), 1);
      check("t5_scnt", 32'(bus.stall_cycles), 11);
      tick();

      // 6: asynchronous reset while draining
      drv(1, OP_ADD, 1, 0, 0, 0, 0, 0); tick();
      drv(0, OP_NOP, 0, 0, 0, 0, 0, 1); tick();
      drv(1, OP_NOP, 0, 0, 0, 0, 0, 1); #1;
      check("t6_pre_stall", 32'(bus.stall), 1);
      resetn = 1'b0;
      #1;
      check("t6_rst_stall", 32'(bus.stall), 0);
      check("t6_rst_busy", 32'(bus.busy), 0);
      check("t6_rst_halted", 32'(bus.halted), 0);
      check("t6_rst_scnt", 32'(bus.stall_cycles), 0);
      check("t6_rst_err", 32'(bus.err_underflow), 0);
      drv(0, OP_NOP, 0, 0, 0, 0, 0, 0); tick();
      resetn = 1'b1;
      drv(1, OP_ADD, 2, 1, 1, 0, 0, 0); #1;
      check("t6_post_issue", 32'(bus.issue), 1);
      tick();
      drv(0, OP_NOP, 0, 0, 0, 1, 2, 0); tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Scoreboard-based issue controller at the ID stage of the 5-stage pipeline. It replaces pure combinational stage-compare hazard detection with per-register pending-write counters.
- Decides each cycle whether the instruction in IF/ID may issue to EX, or must stall.
- Retires pending writes from the WB stage.
- Provides a halt/drain sequencer so the debug path can freeze the pipeline with no writes in flight.

Parameters:
- NUM_REGS, 4, architectural registers tracked (register encodings 0..NUM_REGS-1)
- ENC_W, 2, register encoding width, clog2(NUM_REGS)
- CNT_W, 2, pending-counter width; MAX_PEND = 2^CNT_W-1 = 3
- STALL_W, 16, stall-cycle performance counter width

Ports:
- clk  in  1  pipeline clock, rising edge active
- resetn  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode  in  3  IF/ID instruction bits [6:4]
- id_rd  in  ENC_W  destination register, bits [3:2]
- id_rs1  in  ENC_W  source 1, bits [3:2]
- id_rs2  in  ENC_W  source 2, bits [1:0]
- wb_valid  in  1  a register write retires this cycle (WB regwrite)
- wb_rd  in  ENC_W  retiring destination
- halt_req  in  1  level request to drain and freeze issue
- stall  out  1  hold IF/PC, inject NOP into ID/EX
- issue  out  1  IF/ID advances into ID/EX this cycle
- busy  out  1  any pending counter nonzero
- halted  out  1  FSM in HALTED
- err_underflow  out  1  sticky: retire seen with zero pending
- stall_cycles  out  STALL_W  saturating count of cycles with stall=1

Behaviour:
- Reset (async, resetn=0):
  - all pending counters 0, state RUN
  - halted=0, err_underflow=0, stall_cycles=0, busy=0
  - stall and issue are combinational from inputs and the reset state
- Opcodes come from the shared package: NOP=000, ADD=001, INC=011.
  - writes = (id_opcode != NOP)
  - uses_rs2 = writes && (id_opcode != INC)
- hazard uses registered counters only; a same-cycle retire does not clear a hazard. hazard =
  - pend[id_rs1]!=0, OR
  - uses_rs2 && pend[id_rs2]!=0, OR
  - pend[id_rd]==MAX_PEND
- Stall and issue:
  - stall = id_valid && ((state!=RUN) || (writes && hazard))
  - issue = id_valid && !stall
  - A NOP never hazards. A NOP issues freely in RUN and is blocked in DRAIN/HALTED.
- Counter update at posedge:
  - inc = issue && writes (on id_rd); dec = wb_valid (on wb_rd)
  - same register, inc and dec together: count unchanged
  - different registers: both updated
  - dec at count 0: count stays 0, err_underflow set, cleared only by reset
  - inc at MAX_PEND cannot occur (the hazard blocks it)
- FSM:
  - RUN -> DRAIN when halt_req=1
  - DRAIN -> HALTED when all counters are 0 after this cycle's update
  - DRAIN -> RUN if halt_req drops first
  - HALTED -> RUN when halt_req=0
  - halt_req asserted with nothing in flight: RUN -> DRAIN -> HALTED in 2 cycles
  - Retires still decrement in DRAIN and HALTED.
- stall_cycles: +1 each posedge with stall=1, saturates at all-ones.
- busy = OR of all counters != 0 (registered-count based).
- Latency:
  - issue/stall: 0 cycles, combinational
  - counter effect on hazard: next cycle
  - halted: registered
- Reset mid-operation clears all counters immediately. In-flight writes later retiring set err_underflow only if reset is not applied to the whole pipeline; the system resets all stages together.

Decomposition:
- Shared package linus_pkg:
  - opcode constants NOP/ADD/INC
  - enum sb_state_t {RUN, DRAIN, HALTED}
  - instruction field positions
- One sub-module: sb_pend_counter, a CNT_W-bit up/down counter with inc, dec, zero, max, and underflow-pulse outputs. Instantiate it NUM_REGS times via generate.
- Hazard logic, FSM and perf counter live in issue_scoreboard.

Test Plan:
1. Reset, then ADD (rd=R1, rs1=R1, rs2=R0) with id_valid=1 -> issue=1, pend[1]=1 next cycle.
   - Next INC R1 -> stall=1 for every cycle until wb_valid with wb_rd=1.
   - Then issue=1 on the following cycle; stall_cycles equals the number of stalled cycles.
2. pend[1]=1, present INC (rd=rs1=R0, rs2 field=R1) -> stall=0, issue=1 (rs2 ignored for INC). The same encoding with ADD -> stall=1.
3. pend[0]=1, same cycle: issue ADD R2,R3 and wb_valid with wb_rd=0 -> pend[0]=0, pend[2]=1. Repeat with rd=0 and wb_rd=0 (pend[0] forced to 1 via a prior cycle) -> pend[0] stays 1.
4. All counters 0, wb_valid=1 with wb_rd=3 -> err_underflow=1 and stays 1 through later traffic; pend[3]=0; only resetn=0 clears it.
5. Two writes in flight, halt_req=1 -> state DRAIN, stall=1 even for a NOP.
   - halted=1 one cycle after the second retire.
   - halt_req=0 -> RUN, pending instruction issues.
6. resetn pulsed low mid-cycle with pend[1]=2 and state DRAIN -> counters 0, RUN, halted=0, stall_cycles=0 immediately (asynchronously), without waiting for clk.
